row_ram_responder: RTL
======================

// Module: row_ram_responder
// PURPOSE
//  Responder end of the row-RAM read interface used by the PE datain controller.
//  - Holds two ping-pong banks of input-feature lines, filled by an upstream line loader.
//  - Answers each {row,col,channel} request with an HOUT-wide data row.
//  - Releases a bank when the consumer pulses row_RAM_switch.
//  Sits between the DDR/line loader and the PE datain controller.
// PARAMETERS
//  DATA_WIDTH  8    bits per pixel
//  HOUT        56   pixels per returned row (already padded to a multiple of Iw)
//  K           3    kernel size; rows and cols per request range 0..K-1
//  C           256  channels per bank
//  ROW_WIDTH   10   width of each R_C_Channel field
//  LW          HOUT+K-1  pixels per stored line (localparam)
// PORTS
//  clk            in   1                  clock
//  rst            in   1                  async reset, active-high
//  ld_valid       in   1                  loader line valid
//  ld_ready       out  1                  responder can accept a line
//  ld_data        in   LW*DATA_WIDTH      one stored line, pixel 0 in the LSBs
//  R_C_Channel    in   3*ROW_WIDTH        request fields: [2]=row, [1]=col, [0]=channel
//  row_ready      in   1                  request strobe; R_C_Channel is valid in the same cycle
//  row_RAM_switch in   1                  1-cycle pulse: consumer is done with the read bank
//  data_in        out  HOUT*DATA_WIDTH    returned row, pixel 0 in the LSBs
//  row_valid      out  1                  1-cycle pulse: data_in is valid
//  bank_full      out  2                  per-bank FULL flag
//  err            out  2                  sticky: [0]=request overrun, [1]=switch while not readable
// BEHAVIOUR
//  Reset values
//  - Both banks EMPTY; fill_bank=0, rd_bank=0; line counter=0; no request pending.
//  - Outputs: ld_ready=1, row_valid=0, data_in=0, bank_full=0, err=0.
//  - Reset clears all state even mid-transfer; an in-flight row_valid is not issued.
//  Bank states: EMPTY -> FILLING -> FULL -> EMPTY
//  - EMPTY->FILLING: the first line is accepted into the bank.
//  - FILLING->FULL: line K*C-1 is accepted.
//  - FULL->EMPTY: row_RAM_switch arrives while the bank is rd_bank.
//  Load side
//  - A line is accepted when ld_valid & ld_ready.
//  - It is written to line index row*C+ch of fill_bank. The counter runs 0..K*C-1, channel fastest.
//  - On the last line, fill_bank toggles and the counter wraps to 0.
//  - ld_ready = (bank[fill_bank] != FULL).
//  - ld_ready drops the cycle after the last line only if the other bank is still FULL.
//  Read side
//  - A request is captured into the pending register when row_ready=1 and nothing is pending.
//  - The pending request issues in the first cycle where bank[rd_bank]==FULL; that may be the capture cycle.
//  - row_valid pulses 2 cycles after issue (registered address, then registered read).
//  - Back-to-back: while the bank is FULL, requests sustain 1 per cycle.
//  - Pixel mapping: data_in[i] = line[row*C+ch][col+i] for i=0..HOUT-1.
//  - Indices with col+i >= LW, or with row>=K, col>=K or ch>=C, return 0 (zero padding).
//  - row_ready while a request is pending and not yet issued: the new request is dropped and err[0] is set.
//  Switch
//  - row_RAM_switch with bank[rd_bank]==FULL: that bank becomes EMPTY and rd_bank toggles.
//  - row_RAM_switch with bank[rd_bank]!=FULL: the switch is ignored and err[1] is set.
//  - Requests already issued still complete from the old bank; the read pipeline latches the bank index.
//  - Switch and row_ready in the same cycle: the request targets the new rd_bank and waits until that bank is FULL.
//  - Switch and last-line load in the same cycle: both take effect, so the freed bank can become fill_bank next cycle.
//  bank_full mirrors the two bank states and is registered.
// TESTING
//  1. Reset, load 3*256 lines with pixel = line_idx[7:0]
//     -> bank_full=01, ld_ready stays 1, fill_bank=1.
//  2. Request {1,2,5} on a FULL bank 0
//     -> row_valid 2 cycles later; data_in[i]=(1*256+5)&8'hFF for i<=55; every pixel index is in range (max 2+55=57).
//  3. 8 back-to-back requests on a FULL bank
//     -> 8 consecutive row_valid pulses, order preserved, err=0.
//  4. Request before any bank is FULL, then finish loading
//     -> row_valid exactly 2 cycles after bank_full[0] rises; a second row_ready while pending sets err[0]=1.
//  5. Fill both banks, then pulse switch
//     -> bank_full 11->10, rd_bank=1, ld_ready reasserts; a switch with bank 0 EMPTY and bank 1 FULL (rd_bank=0) sets err[1].
//  6. Assert rst mid-load (line 100) and 1 cycle after a request
//     -> no row_valid, bank_full=00, counter=0, ld_ready=1.

Source files
------------

// File: rtl/row_ram_responder.sv
// row_ram_responder: responder side of the row-RAM read interface.
// Holds two ping-pong banks of input-feature lines written by a line loader
// and answers {row,col,channel} requests with an HOUT-pixel data row.
// Ports:
//   clk, rst             clock, async active-high reset
//   ld_valid/ld_ready    loader handshake; ld_data is one stored line (pixel 0 in LSBs)
//   R_C_Channel          request {row, col, channel}, valid with row_ready
//   row_ready            request strobe
//   row_RAM_switch       consumer releases the current read bank
//   data_in/row_valid    returned row and its 1-cycle valid pulse
//   bank_full            per-bank FULL flags
//   err                  sticky errors: [0] request overrun, [1] bad switch
`timescale 1ns/1ps
module row_ram_responder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned HOUT       = 56,
  parameter int unsigned K          = 3,
  parameter int unsigned C          = 256,
  parameter int unsigned ROW_WIDTH  = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ld_valid,
  output logic                               ld_ready,
  input  logic [(HOUT+K-1)*DATA_WIDTH-1:0]   ld_data,
  input  logic [3*ROW_WIDTH-1:0]             R_C_Channel,
  input  logic                               row_ready,
  input  logic                               row_RAM_switch,
  output logic [HOUT*DATA_WIDTH-1:0]         data_in,
  output logic                               row_valid,
  output logic [1:0]                         bank_full,
  output logic [1:0]                         err
);

  localparam int unsigned LW     = HOUT + K - 1;
  localparam int unsigned LINES  = K * C;
  localparam int unsigned LINE_W = LW * DATA_WIDTH;
  localparam int unsigned OUT_W  = HOUT * DATA_WIDTH;
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned ADDR_W = $clog2(2 * LINES);
  localparam int unsigned COL_W  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned REQ_W  = 3 * ROW_WIDTH;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_e;

  bank_e              bank_q [2];
  bank_e              bank_d [2];
  logic               fill_bank, fill_d;
  logic               rd_bank, rd_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               pend_valid, pend_valid_d;
  logic [REQ_W-1:0]   pend_req, pend_req_d;
  logic [1:0]         err_d;

  logic               ld_fire_c;
  logic               rd_full_c;
  logic               issue_c;
  logic [REQ_W-1:0]   issue_req_c;

  // Read pipeline: stage 1 holds the registered address, stage 2 the read data
  logic               s1_valid;
  logic               s1_bank;
  logic [IDX_W-1:0]   s1_idx;
  logic [COL_W-1:0]   s1_col;
  logic               s1_zero;

  logic [LINE_W-1:0]  mem [2*LINES];

  assign ld_fire_c = ld_valid && ld_ready;
  assign rd_full_c = (bank_q[rd_bank] == FULL);

  // Next-state logic for banks, counters, pending request and error flags
  always_comb begin
    bank_d       = bank_q;
    fill_d       = fill_bank;
    rd_d         = rd_bank;
    cnt_d        = cnt_q;
    pend_valid_d = pend_valid;
    pend_req_d   = pend_req;
    err_d        = err;
    issue_c      = 1'b0;
    issue_req_c  = R_C_Channel;

    if (ld_fire_c) begin
      if (cnt_q == IDX_W'(LINES - 1)) begin
        bank_d[fill_bank] = FULL;
        fill_d            = ~fill_bank;
        cnt_d             = '0;
      end else begin
        bank_d[fill_bank] = FILLING;
        cnt_d             = cnt_q + IDX_W'(1);
      end
    end

    // A FULL read bank is never the fill bank, so this cannot collide with the load above
    if (row_RAM_switch) begin
      if (rd_full_c) begin
        bank_d[rd_bank] = EMPTY;
        rd_d            = ~rd_bank;
      end else begin
        err_d[1] = 1'b1;
      end
    end

    // A switch this cycle retargets requests to the new read bank, so hold off issuing
    if (pend_valid) begin
      if (row_ready) err_d[0] = 1'b1;
      if (rd_full_c && !row_RAM_switch) begin
        issue_c      = 1'b1;
        issue_req_c  = pend_req;
        pend_valid_d = 1'b0;
      end
    end else if (row_ready) begin
      if (rd_full_c && !row_RAM_switch) begin
        issue_c = 1'b1;
      end else begin
        pend_valid_d = 1'b1;
        pend_req_d   = R_C_Channel;
      end
    end
  end

  // Control state and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      fill_bank  <= 1'b0;
      rd_bank    <= 1'b0;
      cnt_q      <= '0;
      pend_valid <= 1'b0;
      pend_req   <= '0;
      err        <= '0;
      ld_ready   <= 1'b1;
      bank_full  <= '0;
    end else begin
      bank_q     <= bank_d;
      fill_bank  <= fill_d;
      rd_bank    <= rd_d;
      cnt_q      <= cnt_d;
      pend_valid <= pend_valid_d;
      pend_req   <= pend_req_d;
      err        <= err_d;
      ld_ready   <= (bank_d[fill_d] != FULL);
      bank_full  <= {bank_d[1] == FULL, bank_d[0] == FULL};
    end
  end

  // Decode the issued request; out-of-range fields yield an all-zero row
  logic [ROW_WIDTH-1:0] iss_row_c, iss_col_c, iss_ch_c;
  logic                 in_range_c;
  assign iss_row_c  = issue_req_c[3*ROW_WIDTH-1 -: ROW_WIDTH];
  assign iss_col_c  = issue_req_c[2*ROW_WIDTH-1 -: ROW_WIDTH];
  assign iss_ch_c   = issue_req_c[ROW_WIDTH-1:0];
  assign in_range_c = (32'(iss_row_c) < K) && (32'(iss_col_c) < K) && (32'(iss_ch_c) < C);

  // Stage 1: latch address and bank so later switches do not disturb in-flight reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_bank  <= 1'b0;
      s1_idx   <= '0;
      s1_col   <= '0;
      s1_zero  <= 1'b0;
    end else begin
      s1_valid <= issue_c;
      if (issue_c) begin
        s1_bank <= rd_bank;
        s1_zero <= !in_range_c;
        s1_idx  <= in_range_c ? IDX_W'(32'(iss_row_c) * C + 32'(iss_ch_c)) : '0;
        s1_col  <= in_range_c ? COL_W'(iss_col_c) : '0;
      end
    end
  end

  // Line storage; bank b occupies addresses b*LINES .. b*LINES+LINES-1
  logic [ADDR_W-1:0] wr_addr_c, rd_addr_c;
  assign wr_addr_c = ADDR_W'(fill_bank ? LINES + 32'(cnt_q) : 32'(cnt_q));
  assign rd_addr_c = ADDR_W'(s1_bank ? LINES + 32'(s1_idx) : 32'(s1_idx));

  always_ff @(posedge clk) begin
    if (ld_fire_c) mem[wr_addr_c] <= ld_data;
  end

  // Shifting right by col pixels fills the tail with zeros past the line end
  logic [LINE_W-1:0] shifted_c;
  assign shifted_c = mem[rd_addr_c] >> (32'(s1_col) * DATA_WIDTH);

  // Stage 2: registered read data and valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_valid <= 1'b0;
      data_in   <= '0;
    end else begin
      row_valid <= s1_valid;
      if (s1_valid) data_in <= s1_zero ? '0 : OUT_W'(shifted_c);
    end
  end

endmodule
